uart_tx_arbiter: RTL

Packet-level round-robin arbiter and sequencer that shares one UART transmit serializer among four byte-stream requesters. It sits between client logic (command responders, debug echo, status reporters) and the UART transmitter, the companion to the UART receive path. It grants the serializer to one requester for a whole packet, issues each byte with a start pulse, and tracks the serializer's busy flag to pace bytes. It also releases the grant on the requester's last byte.

---
 rtl/uart_tx_arbiter_if.sv | 18 +
 rtl/uart_tx_arbiter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester/serializer bundle for the UART transmit arbiter.
// slave = arbiter side, master = clients plus serializer side.
interface uart_tx_arbiter_if;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  last;
    logic [3:0]  ack;
    logic [3:0]  grant;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        aborted;

    modport master (output req, data, last, tx_busy,
                    input  ack, grant, tx_start, tx_data, aborted);
    modport slave  (input  req, data, last, tx_busy,
                    output ack, grant, tx_start, tx_data, aborted);
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART serializer among four requesters.
// Optional owner-idle timeout is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int IDLE_TIMEOUT = 4340
) (
    input logic              clk,
    input logic              reset,
    uart_tx_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t      state, state_n;
    logic [1:0]  ptr, ptr_n, gidx, gidx_n, sel, idx;
    logic [3:0]  grant, grant_n, ack, ack_n;
    logic        start, start_n, last_q, last_n, found, timeout_hit;
    logic [7:0]  txd, txd_n;

    if (IDLE_TIMEOUT < 1) begin : g_bad_cfg
        $error("IDLE_TIMEOUT must be at least 1");
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(IDLE_TIMEOUT + 1);
    logic [CW-1:0] idle_cnt;
    logic          aborted_q;

    // Counter is held at zero outside ISSUE, so it restarts on every ISSUE entry.
    assign timeout_hit = (state == ISSUE) && !bus.req[gidx] &&
                         (idle_cnt == CW'(IDLE_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            idle_cnt  <= '0;
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= timeout_hit;
            if (state != ISSUE || timeout_hit)
                idle_cnt <= '0;
            else if (!bus.req[gidx])
                idle_cnt <= idle_cnt + 1'b1;
        end
    end
    assign bus.aborted = aborted_q;
`else
    assign timeout_hit = 1'b0;
    assign bus.aborted = 1'b0;
`endif

    // Rotating priority: search upward from the slot after the last grantee.
    always_comb begin
        sel   = 2'd0;
        idx   = 2'd0;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && bus.req[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        gidx_n  = gidx;
        grant_n = grant;
        last_n  = last_q;
        txd_n   = txd;
        ack_n   = 4'b0;
        start_n = 1'b0;
        case (state)
            IDLE: if (found) begin
                gidx_n  = sel;
                grant_n = 4'b0001 << sel;
                state_n = ISSUE;
            end
            ISSUE: if (timeout_hit) begin
                ptr_n   = gidx;
                grant_n = 4'b0;
                state_n = IDLE;
            end else if (bus.req[gidx] && !bus.tx_busy) begin
                start_n     = 1'b1;
                txd_n       = bus.data[{gidx, 3'b000} +: 8];
                ack_n[gidx] = 1'b1;
                last_n      = bus.last[gidx];
                state_n     = WAIT_BUSY;
            end
            WAIT_BUSY: if (bus.tx_busy) state_n = WAIT_DONE;
            WAIT_DONE: if (!bus.tx_busy) begin
                if (last_q) begin
                    ptr_n   = gidx;
                    grant_n = 4'b0;
                    state_n = IDLE;
                end else begin
                    state_n = ISSUE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            ptr    <= 2'd3;
            gidx   <= 2'd0;
            grant  <= 4'b0;
            ack    <= 4'b0;
            start  <= 1'b0;
            last_q <= 1'b0;
            txd    <= 8'h00;
        end else begin
            state  <= state_n;
            ptr    <= ptr_n;
            gidx   <= gidx_n;
            grant  <= grant_n;
            ack    <= ack_n;
            start  <= start_n;
            last_q <= last_n;
            txd    <= txd_n;
        end
    end

    assign bus.grant    = grant;
    assign bus.ack      = ack;
    assign bus.tx_start = start;
    assign bus.tx_data  = txd;
endmodule
